conv_viterbi_codec: RTL and testbench
=====================================

// Module: conv_viterbi_codec
// PURPOSE
//  Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) plus a matching 4-state hard-decision Viterbi decoder.
//  Encoder feeds a channel that may flip symbol bits; the decoder restores the data bit stream.
//  Encoder half = encoder2 function; decoder half = decoder function; both share clk/rst.
// PARAMETERS
//  TB_DEPTH  16  survivor (register-exchange) depth in symbols = decoder latency, >=8
//  PM_W      8   path-metric width in bits, unsigned
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  rst          in   1  asynchronous, active-low reset
//  enc_enable_i in   1  encoder input bit valid this cycle
//  enc_d_in     in   1  encoder data bit
//  enc_valid_o  out  1  enc_d_out holds a new symbol (registered)
//  enc_d_out    out  2  code symbol {g0,g1} (registered)
//  dec_enable   in   1  dec_d_in holds a symbol to decode this cycle
//  dec_d_in     in   2  received (possibly corrupted) symbol {g0,g1}
//  dec_d_out    out  1  decoded bit (registered)
// BEHAVIOUR
//  Reset (rst=0, async): enc state=00, enc_valid_o=0, enc_d_out=00, dec_d_out=0,
//   PM[0]=0, PM[1..3]=2**(PM_W-2), all survivor registers=0.
//  Encoder state s={b1,b2} (b1 = previous bit, b2 = bit before it).
//   Edge with enc_enable_i=1: enc_d_out<={d^b1^b2, d^b2}; s<={d,b1}; enc_valid_o<=1.
//   Edge with enc_enable_i=0: s and enc_d_out hold; enc_valid_o<=0.
//   One-cycle latency from input to symbol; back-to-back enables give one symbol per clock.
//  Decoder trellis: state {b1,b2}; input d moves p={p1,p0} to {d,p1}; expected symbol {d^p1^p0, d^p0}.
//   Next state n={d,x} has predecessors {x,0} and {x,1}.
//  Edge with dec_enable=1 (one ACS step):
//   branch metric = Hamming distance(dec_d_in, expected) in 0..2.
//   candidate = PM[p] + BM; survivor = smaller candidate; tie -> predecessor with p0=0.
//   new PM normalised: subtract min over the 4 new metrics so the minimum is 0.
//   Saturate each PM at 2**PM_W-1 (never wraps).
//   survivor reg of state n <= {survivor reg of chosen predecessor, d} (shift left, d in LSB).
//   dec_d_out <= MSB (oldest bit) of survivor reg of pre-edge min-PM state; tie -> lowest index.
//  Edge with dec_enable=0: all decoder state and dec_d_out hold.
//  Latency: bit of the k-th enabled symbol appears on dec_d_out after enabled edge k+TB_DEPTH.
//   First TB_DEPTH outputs after reset are 0 (reset fill).
//  Reset mid-stream: everything returns to reset values at once; decoding restarts from state 0.
//  Correction capability: any pattern with >=5 channel-bit distance between error events
//   (free distance 5) is corrected when errors are spaced > TB_DEPTH/2 symbols apart.
// TESTING
//  Encoder vector: from reset, enable 3 cycles with bits 1,0,0 -> enc_d_out 11,10,11, valid high 3 cycles.
//  Enable gaps: enable 1,0,0,1 with bits 1,x,x,1 -> symbols 11 then 01; valid low during gap, state held.
//  Clean loopback: 256 random bits enc->dec, no errors -> dec_d_out equals input delayed TB_DEPTH enabled symbols, 0 mismatches.
//  Single errors: flip one bit every 16 symbols -> 0 decoded bit errors; PM minimum stays 0.
//  Burst stress: 1-8 symbol random flips ~1/32 cycles -> report BER; no PM wrap (all PM <= 2**PM_W-1).
//  Reset mid-stream: drop rst for 1 cycle at symbol 100 -> outputs 0, PM[0]=0, clean restart decodes correctly.

Source files
------------

// File: rtl/conv_viterbi_codec.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) and a matching
// 4-state hard-decision Viterbi decoder with register-exchange survivors.
module conv_viterbi_codec #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  // Two guard bits so PM + BM never overflows before saturation.
  localparam int unsigned CW = PM_W + 2;
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W - 2){1'b0}}};

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] t;
    t = a ^ b;
    return {t[1] & t[0], t[1] ^ t[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [1:0] enc_state_q;
  logic [1:0] enc_sym_q;
  logic       enc_valid_q;

  // Shift the data bit into the encoder state and register the code symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_q <= 2'b00;
      enc_sym_q   <= 2'b00;
      enc_valid_q <= 1'b0;
    end else begin
      enc_valid_q <= enc_enable_i;
      if (enc_enable_i) begin
        enc_sym_q   <= {enc_d_in ^ enc_state_q[1] ^ enc_state_q[0], enc_d_in ^ enc_state_q[0]};
        enc_state_q <= {enc_d_in, enc_state_q[1]};
      end
    end
  end

  assign enc_valid_o = enc_valid_q;
  assign enc_d_out   = enc_sym_q;

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [CW-1:0]       acc    [4];
  logic [CW-1:0]       min_acc;
  logic                dec_out_q;
  logic                dec_out_d;

  // Add-compare-select for every next state n = {d, x}; predecessors are {x,0} and {x,1}.
  always_comb begin
    logic [1:0]    nn;
    logic [1:0]    pa;
    logic [1:0]    pb;
    logic [1:0]    sel;
    logic [CW-1:0] ca;
    logic [CW-1:0] cb;
    nn  = 2'b00;
    pa  = 2'b00;
    pb  = 2'b00;
    sel = 2'b00;
    ca  = '0;
    cb  = '0;
    min_acc = '1;
    for (int n = 0; n < 4; n++) begin
      nn = 2'(n);
      pa = {nn[0], 1'b0};
      pb = {nn[0], 1'b1};
      ca = {2'b00, pm_q[pa]} + CW'(hamming(dec_d_in, {nn[1] ^ nn[0], nn[1]}));
      cb = {2'b00, pm_q[pb]} + CW'(hamming(dec_d_in, {~(nn[1] ^ nn[0]), ~nn[1]}));
      // Ties resolve to the predecessor whose oldest bit is 0.
      if (cb < ca) begin
        sel    = pb;
        acc[n] = cb;
      end else begin
        sel    = pa;
        acc[n] = ca;
      end
      surv_d[n] = {surv_q[sel][TB_DEPTH-2:0], nn[1]};
      if (acc[n] < min_acc) min_acc = acc[n];
    end
  end

  // Normalise so the best metric is 0, then saturate instead of wrapping.
  always_comb begin
    logic [CW-1:0] norm;
    norm = '0;
    for (int n = 0; n < 4; n++) begin
      norm    = acc[n] - min_acc;
      pm_d[n] = (norm > {2'b00, PM_MAX}) ? PM_MAX : norm[PM_W-1:0];
    end
  end

  // Output the oldest survivor bit of the currently best state (lowest index on ties).
  always_comb begin
    logic [1:0]      best;
    logic [PM_W-1:0] best_pm;
    best    = 2'b00;
    best_pm = pm_q[0];
    for (int n = 1; n < 4; n++) begin
      if (pm_q[n] < best_pm) begin
        best    = 2'(n);
        best_pm = pm_q[n];
      end
    end
    dec_out_d = surv_q[best][TB_DEPTH-1];
  end

  // Decoder state advances only on enabled symbols.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      dec_out_q <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      dec_out_q <= dec_out_d;
    end
  end

  assign dec_d_out = dec_out_q;

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Directed bench for conv_viterbi_codec: encoder vectors, clean/noisy loopback, reset mid-stream.
module tb_conv_viterbi_codec;

  localparam int TBD = 16;
  localparam int PMW = 8;
  localparam logic [7:0] PM_INIT = 8'd64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       dec_d_out;

  int checks = 0;
  int errors = 0;
  int dec_cnt = 0;
  int bit_errs = 0;
  logic [1:0] m_s = 2'b00;
  bit tx[$];

  conv_viterbi_codec #(.TB_DEPTH(TBD), .PM_W(PMW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_d_out    (dec_d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_enc_valid", {7'd0, enc_valid_o}, 8'd0);
    check("rst_enc_sym", {6'd0, enc_d_out}, 8'd0);
    check("rst_dec_out", {7'd0, dec_d_out}, 8'd0);
    check("rst_pm0", dut.pm_q[0], 8'd0);
    check("rst_pm1", dut.pm_q[1], PM_INIT);
    check("rst_pm2", dut.pm_q[2], PM_INIT);
    check("rst_pm3", dut.pm_q[3], PM_INIT);
  endtask

  // Asynchronous reset pulse: checked before any clock edge, held across one edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tx.delete();
    dec_cnt = 0;
    m_s = 2'b00;
  endtask

  task automatic enc_step(input logic en, input logic d);
    enc_enable_i = en;
    enc_d_in = d;
    dec_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One loopback clock: encoder takes bit b, decoder takes the previous symbol xor err.
  task automatic lb_cycle(input logic b, input logic [1:0] err, input bit chk_dec,
                          input bit chk_pm);
    logic       took;
    logic [1:0] exp_sym;
    logic       exp_bit;
    logic [7:0] pmin;
    took = enc_valid_o;
    enc_enable_i = 1'b1;
    enc_d_in = b;
    dec_enable = enc_valid_o;
    dec_d_in = enc_d_out ^ err;
    exp_sym = {b ^ m_s[1] ^ m_s[0], b ^ m_s[0]};
    m_s = {b, m_s[1]};
    tx.push_back(b);
    @(posedge clk);
    #1;
    check("lb_enc_sym", {6'd0, enc_d_out}, {6'd0, exp_sym});
    if (took) begin
      dec_cnt++;
      exp_bit = (dec_cnt > TBD) ? tx[dec_cnt-TBD-1] : 1'b0;
      if (dec_d_out !== exp_bit) bit_errs++;
      if (chk_dec) check("lb_dec_bit", {7'd0, dec_d_out}, {7'd0, exp_bit});
      if (chk_pm) begin
        pmin = dut.pm_q[0];
        for (int i = 1; i < 4; i++) if (dut.pm_q[i] < pmin) pmin = dut.pm_q[i];
        check("pm_min_zero", pmin, 8'd0);
      end
    end
  endtask

  initial begin
    logic [1:0] err;
    int burst_left;

    // Reset state, observed while reset is asserted.
    #12;
    check_reset_state();
    rst = 1'b1;

    // Encoder vector 1,0,0 -> 11,10,11; then idle: valid drops, symbol holds.
    enc_step(1'b1, 1'b1);
    check("enc_v1_sym", {6'd0, enc_d_out}, 8'h03);
    check("enc_v1_valid", {7'd0, enc_valid_o}, 8'd1);
    enc_step(1'b1, 1'b0);
    check("enc_v2_sym", {6'd0, enc_d_out}, 8'h02);
    check("enc_v2_valid", {7'd0, enc_valid_o}, 8'd1);
    enc_step(1'b1, 1'b0);
    check("enc_v3_sym", {6'd0, enc_d_out}, 8'h03);
    check("enc_v3_valid", {7'd0, enc_valid_o}, 8'd1);
    enc_step(1'b0, 1'b1);
    check("enc_idle_valid", {7'd0, enc_valid_o}, 8'd0);
    check("enc_idle_sym", {6'd0, enc_d_out}, 8'h03);

    // Enable gaps: 1,x,x,1 -> 11 then 01; state held across the gap.
    pulse_reset();
    enc_step(1'b1, 1'b1);
    check("gap_sym1", {6'd0, enc_d_out}, 8'h03);
    enc_step(1'b0, 1'b0);
    check("gap_valid1", {7'd0, enc_valid_o}, 8'd0);
    check("gap_hold1", {6'd0, enc_d_out}, 8'h03);
    enc_step(1'b0, 1'b1);
    check("gap_valid2", {7'd0, enc_valid_o}, 8'd0);
    enc_step(1'b1, 1'b1);
    check("gap_sym2", {6'd0, enc_d_out}, 8'h01);
    check("gap_valid3", {7'd0, enc_valid_o}, 8'd1);
    check("gap_dec_idle", {7'd0, dec_d_out}, 8'd0);

    // Clean loopback.
    pulse_reset();
    for (int i = 0; i < 256; i++) lb_cycle(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b0);

    // Single symbol-bit error every 16 symbols.
    for (int i = 0; i < 256; i++) begin
      err = (i % 16 == 8) ? (((i / 16) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      lb_cycle(1'($urandom_range(0, 1)), err, 1'b1, 1'b1);
    end

    // Burst stress: only metric normalisation is required; BER is reported.
    bit_errs = 0;
    burst_left = 0;
    for (int i = 0; i < 256; i++) begin
      err = 2'b00;
      if (burst_left > 0) begin
        err = 2'($urandom_range(1, 3));
        burst_left--;
      end else if ($urandom_range(0, 31) == 0) begin
        burst_left = $urandom_range(1, 8);
      end
      lb_cycle(1'($urandom_range(0, 1)), err, 1'b0, 1'b1);
    end
    $display("Burst stress: %0d decoded bit errors over %0d decoded bits", bit_errs, 256);

    // Reset at symbol 100 of a clean stream, then a clean restart.
    pulse_reset();
    for (int i = 0; i < 100; i++) lb_cycle(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b0);
    pulse_reset();
    for (int i = 0; i < 100; i++) lb_cycle(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
